// File: rtl/vec_pkg.sv
// Shared definitions for the vector write-back stage.
// Provides flag bit positions within a {V,N,Z,C} nibble, the ALU opcode
// values the write-back path cares about, and the skid-buffer FSM states.
package vec_pkg;

    // Bit positions inside a {V,N,Z,C} flag nibble
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

    // ALU opcodes relevant to write-back
    localparam logic [2:0] OP_MUL = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SET = 3'b111;

    // Skid buffer occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } wb_state_e;

endpackage : vec_pkg

// File: rtl/vec_flag_reduce.sv
// Combinational lane reduction for the write-back stage.
// Ports:
//   result_i  LANES*WIDTH  raw lane results
//   flags_i   LANES*4      raw lane flags {V,N,Z,C}
//   opcode_i  3            ALU opcode (used only for saturation)
//   mask_i    LANES        active lanes
//   data_c    LANES*WIDTH  write data, inactive lanes zeroed
//   vflags_c  4            reduced flags over active lanes
// Optional: VEC_WB_SATURATE_EN clamps overflowed add/sub lanes.
module vec_flag_reduce
    import vec_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4
) (
    input  logic [LANES*WIDTH-1:0] result_i,
    input  logic [LANES*4-1:0]     flags_i,
    input  logic [2:0]             opcode_i,
    input  logic [LANES-1:0]       mask_i,
    output logic [LANES*WIDTH-1:0] data_c,
    output logic [3:0]             vflags_c
);

    logic [WIDTH-1:0] lane_res;

`ifdef VEC_WB_SATURATE_EN
    logic arith_op;
    assign arith_op = (opcode_i == OP_SUB) || (opcode_i == OP_ADD);
`else
    logic unused_opcode;
    assign unused_opcode = ^opcode_i;
`endif

    // Z is an AND over active lanes, so an empty mask leaves Z=1 alone
    always_comb begin
        vflags_c         = '0;
        vflags_c[FLAG_Z] = 1'b1;
        data_c           = '0;
        lane_res         = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (mask_i[i]) begin
                vflags_c[FLAG_C] = vflags_c[FLAG_C] | flags_i[i*4 + FLAG_C];
                vflags_c[FLAG_N] = vflags_c[FLAG_N] | flags_i[i*4 + FLAG_N];
                vflags_c[FLAG_V] = vflags_c[FLAG_V] | flags_i[i*4 + FLAG_V];
                vflags_c[FLAG_Z] = vflags_c[FLAG_Z] & flags_i[i*4 + FLAG_Z];
                lane_res = result_i[i*WIDTH +: WIDTH];
`ifdef VEC_WB_SATURATE_EN
                // Wrapped MSB=1 means positive overflow, so clamp to max positive
                if (arith_op && flags_i[i*4 + FLAG_V]) begin
                    lane_res = lane_res[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                                 : {1'b1, {(WIDTH-1){1'b0}}};
                end
`endif
                data_c[i*WIDTH +: WIDTH] = lane_res;
            end
        end
    end

endmodule : vec_flag_reduce

// File: rtl/vec_wb_stage.sv
// Vector write-back stage: registers lane results/flags behind a 2-entry
// skid buffer and drives a masked register-file write.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready                upstream handshake
//   in_result/in_flags/in_opcode     lane results, flags {V,N,Z,C}, opcode
//   in_lane_mask/in_rd/in_wb_en      active lanes, destination, write enable
//   wb_valid/wb_ready                register-file handshake
//   wb_addr/wb_data/wb_lane_we       head-entry write
//   vflags                           reduced flags of head entry
//   sticky_v/clr_sticky              sticky overflow and its clear
// Optional: VEC_WB_SATURATE_EN (saturating add/sub write data).
module vec_wb_stage
    import vec_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*WIDTH-1:0]  in_result,
    input  logic [LANES*4-1:0]      in_flags,
    input  logic [2:0]              in_opcode,
    input  logic [LANES-1:0]        in_lane_mask,
    input  logic [REG_ADDR_W-1:0]   in_rd,
    input  logic                    in_wb_en,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [REG_ADDR_W-1:0]   wb_addr,
    output logic [LANES*WIDTH-1:0]  wb_data,
    output logic [LANES-1:0]        wb_lane_we,
    output logic [3:0]              vflags,
    output logic                    sticky_v,
    input  logic                    clr_sticky
);

    localparam int unsigned DATA_W = LANES * WIDTH;

    wb_state_e               state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic                    wb_valid_q, wb_valid_d;
    logic                    sticky_q, sticky_d;
    logic [REG_ADDR_W-1:0]   head_addr_q, head_addr_d, skid_addr_q, skid_addr_d;
    logic [DATA_W-1:0]       head_data_q, head_data_d, skid_data_q, skid_data_d;
    logic [LANES-1:0]        head_we_q, head_we_d, skid_we_q, skid_we_d;
    logic [3:0]              head_vf_q, head_vf_d, skid_vf_q, skid_vf_d;

    logic [DATA_W-1:0]       new_data_c;
    logic [3:0]              new_vf_c;
    logic [LANES-1:0]        new_we_c;
    logic                    accept_c;
    logic                    retire_c;

    vec_flag_reduce #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_reduce (
        .result_i (in_result),
        .flags_i  (in_flags),
        .opcode_i (in_opcode),
        .mask_i   (in_lane_mask),
        .data_c   (new_data_c),
        .vflags_c (new_vf_c)
    );

    assign new_we_c = in_lane_mask & {LANES{in_wb_en}};
    assign accept_c = in_valid && in_ready_q;
    assign retire_c = wb_valid_q && wb_ready;

    // Next-state and entry movement
    always_comb begin
        state_d     = state_q;
        head_addr_d = head_addr_q;
        head_data_d = head_data_q;
        head_we_d   = head_we_q;
        head_vf_d   = head_vf_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
        skid_we_d   = skid_we_q;
        skid_vf_d   = skid_vf_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    head_addr_d = in_rd;
                    head_data_d = new_data_c;
                    head_we_d   = new_we_c;
                    head_vf_d   = new_vf_c;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept_c && !retire_c) begin
                    skid_addr_d = in_rd;
                    skid_data_d = new_data_c;
                    skid_we_d   = new_we_c;
                    skid_vf_d   = new_vf_c;
                    state_d     = ST_FULL;
                end else if (accept_c && retire_c) begin
                    head_addr_d = in_rd;
                    head_data_d = new_data_c;
                    head_we_d   = new_we_c;
                    head_vf_d   = new_vf_c;
                end else if (retire_c) begin
                    // Keep write enables low whenever nothing is presented
                    head_we_d = '0;
                    state_d   = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (retire_c) begin
                    head_addr_d = skid_addr_q;
                    head_data_d = skid_data_q;
                    head_we_d   = skid_we_q;
                    head_vf_d   = skid_vf_q;
                    state_d     = ST_ONE;
                end
            end
            default: begin
                head_we_d = '0;
                state_d   = ST_EMPTY;
            end
        endcase

        in_ready_d = (state_d != ST_FULL);
        wb_valid_d = (state_d != ST_EMPTY);
        // Set wins over clear
        sticky_d   = (retire_c && head_vf_q[FLAG_V]) || (sticky_q && !clr_sticky);
    end

    // State and entry registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            wb_valid_q  <= 1'b0;
            sticky_q    <= 1'b0;
            head_addr_q <= '0;
            head_data_q <= '0;
            head_we_q   <= '0;
            head_vf_q   <= '0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
            skid_we_q   <= '0;
            skid_vf_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            wb_valid_q  <= wb_valid_d;
            sticky_q    <= sticky_d;
            head_addr_q <= head_addr_d;
            head_data_q <= head_data_d;
            head_we_q   <= head_we_d;
            head_vf_q   <= head_vf_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
            skid_we_q   <= skid_we_d;
            skid_vf_q   <= skid_vf_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign wb_valid   = wb_valid_q;
    assign wb_addr    = head_addr_q;
    assign wb_data    = head_data_q;
    assign wb_lane_we = head_we_q;
    assign vflags     = head_vf_q;
    assign sticky_v   = sticky_q;

endmodule : vec_wb_stage

// File: tb/tb_vec_wb_stage.sv
// Scoreboard bench for vec_wb_stage: expected beats are queued at accept
// and a negedge monitor compares every presented head entry.
module tb_vec_wb_stage;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LANES = 4;
    localparam int unsigned AW    = 4;

    typedef struct {
        logic [AW-1:0]          addr;
        logic [LANES*WIDTH-1:0] data;
        logic [LANES-1:0]       we;
        logic [3:0]             vf;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_result = '0;
    logic [LANES*4-1:0]     in_flags = '0;
    logic [2:0]             in_opcode = '0;
    logic [LANES-1:0]       in_lane_mask = '0;
    logic [AW-1:0]          in_rd = '0;
    logic                   in_wb_en = 1'b0;
    logic                   wb_valid;
    logic                   wb_ready = 1'b0;
    logic [AW-1:0]          wb_addr;
    logic [LANES*WIDTH-1:0] wb_data;
    logic [LANES-1:0]       wb_lane_we;
    logic [3:0]             vflags;
    logic                   sticky_v;
    logic                   clr_sticky = 1'b0;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_sticky = 1'b0;
    logic rand_ready = 1'b0;

    always #5 clk = ~clk;

    vec_wb_stage #(.WIDTH(WIDTH), .LANES(LANES), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_opcode(in_opcode),
        .in_lane_mask(in_lane_mask), .in_rd(in_rd), .in_wb_en(in_wb_en),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_lane_we(wb_lane_we), .vflags(vflags),
        .sticky_v(sticky_v), .clr_sticky(clr_sticky)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: reduction and write data straight from the lane rules
    function automatic exp_t model(input logic [31:0] res, input logic [15:0] flg,
                                   input logic [2:0] op, input logic [3:0] mask,
                                   input logic [3:0] rd, input logic wben);
        exp_t e;
        logic [3:0] f;
        logic [7:0] r;
        logic c = 1'b0, z = 1'b1, n = 1'b0, v = 1'b0;
        e.addr = rd;
        e.data = '0;
        e.we   = wben ? mask : 4'b0000;
        for (int l = 0; l < 4; l++) begin
            if (mask[l]) begin
                f = flg[l*4 +: 4];
                r = res[l*8 +: 8];
                c = c | f[0];
                z = z & f[1];
                n = n | f[2];
                v = v | f[3];
`ifdef VEC_WB_SATURATE_EN
                if ((op == 3'b001 || op == 3'b010) && f[3])
                    r = r[7] ? 8'h7F : 8'h80;
`endif
                e.data[l*8 +: 8] = r;
            end
        end
        e.vf = {v, n, z, c};
        return e;
    endfunction

    // Monitor: compares head entry and sticky every cycle
    always @(negedge clk) begin
        logic retv;
        retv = 1'b0;
        if (!rst_n) begin
            exp_sticky = 1'b0;
        end else begin
            chk("sticky_v", 64'(sticky_v), 64'(exp_sticky));
            if (wb_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'(wb_valid), 64'd0);
                end else begin
                    chk("wb_addr", 64'(wb_addr), 64'(q[0].addr));
                    chk("wb_data", 64'(wb_data), 64'(q[0].data));
                    chk("wb_lane_we", 64'(wb_lane_we), 64'(q[0].we));
                    chk("vflags", 64'(vflags), 64'(q[0].vf));
                    if (wb_ready) begin
                        retv = q[0].vf[3];
                        void'(q.pop_front());
                    end
                end
            end else begin
                chk("we_idle", 64'(wb_lane_we), 64'd0);
            end
            exp_sticky = (wb_valid && wb_ready && retv) || (exp_sticky && !clr_sticky);
        end
    end

    // Issue one beat; returns just after the accepting edge
    task automatic send(input logic [31:0] res, input logic [15:0] flg, input logic [2:0] op,
                        input logic [3:0] mask, input logic [3:0] rd, input logic wben);
        bit ok = 0;
        in_result = res; in_flags = flg; in_opcode = op;
        in_lane_mask = mask; in_rd = rd; in_wb_en = wben; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
            @(posedge clk); #1;
            if (rand_ready) wb_ready = 1'($urandom_range(0, 1));
        end
        if (!ok) begin
            chk("accept_timeout", 64'd1, 64'd0);
        end else begin
            @(posedge clk);
            q.push_back(model(res, flg, op, mask, rd, wben));
        end
        #1;
        in_valid = 1'b0;
        if (rand_ready) wb_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        wb_ready = 1'b1;
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [7:0] sat_exp;
        // Reset values
        #12; rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_addr", 64'(wb_addr), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_vflags", 64'(vflags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Single beat, one-cycle latency
        wb_ready = 1'b1;
        send(32'h01020304, 16'h0000, 3'b010, 4'b1111, 4'd3, 1'b1);
        @(negedge clk);
        chk("latency_valid", 64'(wb_valid), 64'd1);
        chk("single_addr", 64'(wb_addr), 64'd3);
        chk("single_data", 64'(wb_data), 64'h01020304);
        drain();

        // Backpressure: two accepts fill the stage
        wb_ready = 1'b0;
        send(32'hAAAA0001, 16'h0000, 3'b000, 4'b1111, 4'd1, 1'b1);
        send(32'hBBBB0002, 16'h0000, 3'b000, 4'b0011, 4'd2, 1'b1);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        tick(3);
        wb_ready = 1'b1;
        send(32'hCCCC0003, 16'h0000, 3'b000, 4'b1100, 4'd4, 1'b0);
        drain();

        // Flag reduction and sticky set
        send(32'h11223344, 16'h5A52, 3'b011, 4'b0101, 4'd5, 1'b1);
        @(negedge clk);
        chk("reduce_vflags", 64'(vflags), 64'hA);
        drain();
        @(negedge clk);
        chk("sticky_set", 64'(sticky_v), 64'd1);
        @(posedge clk); #1;
        send(32'hFFFFFFFF, 16'hFFFF, 3'b100, 4'b0000, 4'd6, 1'b1);
        @(negedge clk);
        chk("mask0_vflags", 64'(vflags), 64'h2);
        chk("mask0_we", 64'(wb_lane_we), 64'd0);
        drain();

        // Sticky clear, then clear racing a V retire
        clr_sticky = 1'b1; tick(1); clr_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_clr", 64'(sticky_v), 64'd0);
        @(posedge clk); #1;
        send(32'h00000000, 16'h0008, 3'b010, 4'b0001, 4'd7, 1'b1);
        clr_sticky = 1'b1; tick(1); clr_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_race", 64'(sticky_v), 64'd1);
        @(posedge clk); #1;
        clr_sticky = 1'b1; tick(1); clr_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_clr2", 64'(sticky_v), 64'd0);
        @(posedge clk); #1;

        // Saturation on ADD, none on MUL
`ifdef VEC_WB_SATURATE_EN
        sat_exp = 8'h7F;
`else
        sat_exp = 8'h80;
`endif
        send(32'h00000080, 16'h0008, 3'b010, 4'b0001, 4'd8, 1'b1);
        @(negedge clk);
        chk("sat_add", 64'(wb_data[7:0]), 64'(sat_exp));
        drain();
        send(32'h00000080, 16'h0008, 3'b000, 4'b0001, 4'd9, 1'b1);
        @(negedge clk);
        chk("sat_mul", 64'(wb_data[7:0]), 64'h80);
        drain();
        clr_sticky = 1'b1; tick(1); clr_sticky = 1'b0;

        // Randomized traffic with random backpressure and clears
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            clr_sticky = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                tick(1);
                wb_ready = 1'($urandom_range(0, 1));
            end
            send($urandom, 16'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end
        clr_sticky = 1'b0;
        rand_ready = 1'b0;
        drain();

        // Reset while FULL with sticky set
        send(32'h0, 16'h0008, 3'b001, 4'b0001, 4'd10, 1'b1);
        drain();
        wb_ready = 1'b0;
        send(32'h12345678, 16'h0000, 3'b000, 4'b1111, 4'd11, 1'b1);
        send(32'h9ABCDEF0, 16'h8888, 3'b000, 4'b1111, 4'd12, 1'b1);
        @(negedge clk);
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        chk("pre_rst_sticky", 64'(sticky_v), 64'd1);
        #2; rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_valid", 64'(wb_valid), 64'd0);
        chk("midrst_we", 64'(wb_lane_we), 64'd0);
        chk("midrst_sticky", 64'(sticky_v), 64'd0);
        @(negedge clk); @(negedge clk);
        #2; rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        wb_ready = 1'b1;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_vec_wb_stage

// File: doc/vec_wb_stage.md
Name: vec_wb_stage

Overview:
- Downstream of the vector ALU lanes: registers per-lane results and flags from all LANES ALU instances and drives a masked write into the vector register file.
- Reduces lane flags into one vector flag nibble and keeps a sticky overflow bit.
- Valid/ready on both sides; a 2-entry skid buffer gives full throughput with registered outputs.

Parameters:
- WIDTH, 8, lane data width in bits; matches the ALU WIDTH.
- LANES, 4, number of ALU lanes.
- REG_ADDR_W, 4, vector register file address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_result  in  LANES*WIDTH  lane results; lane i at [i*WIDTH +: WIDTH].
- in_flags  in  LANES*4  lane flags {V,N,Z,C}; lane i at [i*4 +: 4].
- in_opcode  in  3  ALU opcode of the beat.
- in_lane_mask  in  LANES  active lanes.
- in_rd  in  REG_ADDR_W  destination register.
- in_wb_en  in  1  beat writes the register file; 0 means flags only.
- wb_valid  out  1  write/flags beat valid.
- wb_ready  in  1  register file accepts.
- wb_addr  out  REG_ADDR_W  destination register.
- wb_data  out  LANES*WIDTH  write data.
- wb_lane_we  out  LANES  per-lane write enable; in_lane_mask & {LANES{in_wb_en}}.
- vflags  out  4  reduced flags {V,N,Z,C} of the head beat.
- sticky_v  out  1  sticky overflow.
- clr_sticky  in  1  clears sticky_v.

Behaviour:
- Handshake: in accepted when in_valid && in_ready; out retired when wb_valid && wb_ready.
- Outputs hold stable while wb_valid && !wb_ready.
- Storage: 2 entries, head and skid. FSM states are EMPTY, ONE, FULL.
- in_ready = (state != FULL). It is registered and depends only on state, with no combinational path from wb_ready.
- wb_valid = (state != EMPTY). Output fields come from the head entry.
- EMPTY:
  - accept -> ONE.
- ONE:
  - accept only -> FULL; the new beat goes to the skid entry.
  - retire only -> EMPTY.
  - accept and retire together -> ONE; the new beat goes to the head entry.
- FULL:
  - retire -> ONE; skid moves to head.
  - No accept is possible in FULL.
- Latency: 1 cycle from accept to wb_valid when the stage was empty. Throughput: 1 beat per cycle while wb_ready=1.
- Reduction is computed at accept over active lanes only and stored with the beat:
  - C = OR of C
  - N = OR of N
  - V = OR of V
  - Z = AND of Z
- If in_lane_mask = 0: vflags = 4'b0010 (Z=1 only).
- wb_data for an inactive lane is 0.
- sticky_v:
  - Set on a retire whose vflags.V = 1.
  - Cleared by clr_sticky.
  - If set and clear happen in the same cycle, set wins.
- Opcodes 3'b011..3'b110 are treated as written: flags pass as given. No opcode decoding except under the optional feature below.
- Reset, asynchronous and honoured at any point including mid-transfer:
  - State EMPTY; in_ready = 1 on the first cycle after deassertion.
  - wb_valid = 0, wb_addr = 0, wb_data = 0, wb_lane_we = 0, vflags = 0, sticky_v = 0.
  - All in-flight beats are discarded.
- Entry contents are don't-care when invalid. wb_lane_we must be 0 whenever wb_valid = 0.

Optional Feature:
- Macro: VEC_WB_SATURATE_EN.
- Defined:
  - For opcodes 3'b001 (sub) and 3'b010 (add), an active lane with V = 1 is clamped.
  - Raw result MSB = 1 -> written value is 2^(WIDTH-1)-1 (0x7F at WIDTH=8).
  - Raw result MSB = 0 -> written value is -2^(WIDTH-1) (0x80).
  - Multiply (3'b000) and set (3'b111) are never clamped.
  - vflags and sticky_v still use the raw flags.
- Undefined: results are written unmodified. No saturation logic is synthesised.

Decomposition:
- Shared package vec_pkg:
  - Flag bit index constants FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3.
  - Opcode constants OP_MUL=3'b000, OP_SUB=3'b001, OP_ADD=3'b010, OP_SET=3'b111.
  - Typedef for the FSM state enum.
- One sub-module, vec_flag_reduce: combinational, LANES-parameterised. It performs the mask-qualified flag reduction and, under the macro, the per-lane saturation. The top level holds the FSM, entries and sticky register.

Test Plan:
- Reset then single beat. Stimulus: mask 4'b1111, rd 3, wb_en 1, results {0x01,0x02,0x03,0x04}, lane flags all 0, wb_ready 1. Response: next cycle wb_valid 1, wb_addr 3, wb_lane_we 4'b1111, data matches, vflags 0.
- Backpressure. Stimulus: hold wb_ready 0 and send 3 consecutive beats. Response: in_ready drops after 2 accepts. Release wb_ready: beats emerge in order with no loss or duplication; outputs stable while stalled.
- Flag reduction. Stimulus: mask 4'b0101, lane0 flags 4'b0010, lane2 flags 4'b1010, lanes 1 and 3 flags 4'b0101. Response: vflags 4'b1010, sticky_v 1 after retire. Stimulus: mask 0. Response: vflags 4'b0010, wb_lane_we 0.
- Sticky clear race. Stimulus: clr_sticky in the same cycle as retiring a V=1 beat. Response: sticky_v stays 1. Stimulus: clr_sticky alone. Response: sticky_v 0.
- Saturation (macro defined). Stimulus: opcode ADD, lane result 0x80, flags V=1. Response: written 0x7F. Same result with opcode MUL. Response: written 0x80. Macro undefined. Response: 0x80 in both cases.
- Reset mid-operation. Stimulus: assert rst_n low while in FULL. Response: immediately wb_valid 0, wb_lane_we 0, sticky_v 0; after release in_ready 1 and no stale beat emitted.
